// File: rtl/regfile_dump_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_if
// Purpose  : Bus bundle between the register-file dump engine, the register
//            file read port and the word consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_dump_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
);
    logic             start;
    logic [SEL_W-1:0] rf_sel;
    logic [WIDTH-1:0] rf_data;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_idx;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;

    // Seen from the dump engine.
    modport slave (
        input  start, rf_data, out_ready,
        output rf_sel, out_data, out_idx, out_last, out_valid, busy, done
    );

    // Seen from the surrounding datapath / consumer.
    modport master (
        output start, rf_data, out_ready,
        input  rf_sel, out_data, out_idx, out_last, out_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Purpose  : Walks the register-file read select from R0 up and streams each
//            register value out over valid/ready. Optional trailing checksum
//            word is enabled by defining REGFILE_DUMP_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 16,
    parameter int SEL_W    = 3
) (
    input  wire logic      clk,
    input  wire logic      reset,
    regfile_dump_if.slave  bus
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        SUM     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } state_t;
`endif

    state_t           state_q,    state_d;
    logic [SEL_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_idx_q,  out_idx_d;
    logic             out_last_q, out_last_d;
    logic             done_q,     done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q,      sum_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
            done_q     <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
        done_d     = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    cnt_d   = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            FETCH: begin
                // Capture here so later register writes cannot disturb the presented word.
                out_data_d = bus.rf_data;
                out_idx_d  = cnt_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                out_last_d = 1'b0;
                sum_d      = sum_q + bus.rf_data;
`else
                out_last_d = (cnt_q == LAST_IDX);
`endif
                state_d    = PRESENT;
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    if (cnt_q != LAST_IDX) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FETCH;
                    end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        out_data_d = sum_q;
                        out_idx_d  = '0;
                        out_last_d = 1'b1;
                        state_d    = SUM;
`else
                        state_d    = IDLE;
                        done_d     = 1'b1;
`endif
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            SUM: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rf_sel    = (state_q == FETCH || state_q == PRESENT) ? cnt_q : '0;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    assign bus.out_valid = (state_q == PRESENT) || (state_q == SUM);
`else
    assign bus.out_valid = (state_q == PRESENT);
`endif
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump
// Purpose  : Self-checking bench for regfile_dump with a negedge-written
//            register file model and directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump;

    localparam int NUM_REGS = 8;
    localparam int WIDTH    = 16;
    localparam int SEL_W    = 3;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int NCYC     = 18;
    localparam int NWORDS   = 9;
`else
    localparam int NCYC     = 17;
    localparam int NWORDS   = 8;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_dump_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    regfile_dump #(
        .NUM_REGS (NUM_REGS),
        .WIDTH    (WIDTH),
        .SEL_W    (SEL_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [WIDTH-1:0] rf [NUM_REGS];
    assign bus.rf_data = rf[bus.rf_sel];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic             valid;
        logic             busy;
        logic             done;
        logic [SEL_W-1:0] idx;
        logic [WIDTH-1:0] data;
        logic             last;
    } vec_t;
    vec_t vt [NCYC + 2];

    logic [WIDTH-1:0] got_data [16];
    logic [SEL_W-1:0] got_idx  [16];
    logic             got_last [16];
    int               got_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq();
        for (int i = 0; i < NUM_REGS; i++) rf[i] = 16'(16'h1000 + i);
    endtask

    // Start is raised now and sampled on the next edge; returns in cycle 1 (FETCH).
    task automatic start_dump();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idx(input int idx, input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (bus.out_valid && int'(bus.out_idx) == idx) found = 1'b1;
            else tick();
        end
        check({name, "_reach"}, 64'(found), 64'(1));
    endtask

    // Logs transfers until done; returns in the done cycle without advancing.
    task automatic collect(input int budget, input int pulse_idx,
                           output bit saw_done, output int done_c);
        bit pulsed = 1'b0;
        bit drop   = 1'b0;
        saw_done = 1'b0;
        done_c   = 0;
        got_n    = 0;
        for (int c = 1; c <= budget && !saw_done; c++) begin
            if (bus.done) begin
                saw_done = 1'b1;
                done_c   = c;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (got_n < 16) begin
                        got_data[got_n] = bus.out_data;
                        got_idx[got_n]  = bus.out_idx;
                        got_last[got_n] = bus.out_last;
                    end
                    got_n++;
                end
                if (pulse_idx >= 0 && !pulsed && bus.out_valid && int'(bus.out_idx) == pulse_idx) begin
                    bus.start = 1'b1;
                    pulsed    = 1'b1;
                    drop      = 1'b1;
                end
                tick();
                if (drop) begin
                    bus.start = 1'b0;
                    drop      = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_done;
        int done_c;

        for (int c = 1; c <= NCYC + 1; c++) begin
            vt[c].valid = (c % 2 == 0) && (c <= 16);
            vt[c].idx   = SEL_W'(c / 2 - 1);
            vt[c].data  = 16'(16'h1000 + c / 2 - 1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
            vt[c].last  = 1'b0;
            if (c == 17) begin
                vt[c].valid = 1'b1;
                vt[c].idx   = '0;
                vt[c].data  = 16'h801C;
                vt[c].last  = 1'b1;
            end
`else
            vt[c].last  = (c == 16);
`endif
            vt[c].busy  = (c < NCYC);
            vt[c].done  = (c == NCYC);
        end

        load_seq();
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        reset         = 1'b0;

        // Reset held with start high
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("reset_hold_%0d", i),
                  64'({bus.out_valid, bus.busy, bus.done, bus.out_last,
                       bus.out_idx, bus.out_data, bus.rf_sel}), 64'(0));
        end
        reset     = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_reset_idle_%0d", i),
                  64'({bus.out_valid, bus.busy, bus.done}), 64'(0));
        end

        // Streaming dump, table-driven cycle by cycle
        start_dump();
        for (int c = 1; c <= NCYC + 1; c++) begin
            check($sformatf("stream_ctl_c%0d", c),
                  64'({bus.out_valid, bus.busy, bus.done}),
                  64'({vt[c].valid, vt[c].busy, vt[c].done}));
            if (vt[c].valid)
                check($sformatf("stream_word_c%0d", c),
                      64'({bus.out_idx, bus.out_data, bus.out_last}),
                      64'({vt[c].idx, vt[c].data, vt[c].last}));
            tick();
        end

        // Backpressure on idx 3 with a register rewrite underneath
        load_seq();
        rf[3] = 16'hBEEF;
        start_dump();
        wait_idx(3, 20, "bp_idx3");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_%0d", i),
                  64'({bus.out_valid, bus.out_idx, bus.out_data}),
                  64'({1'b1, 3'd3, 16'hBEEF}));
            if (i == 1) @(negedge clk) rf[3] = 16'h0000;
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_fetch_gap", 64'({bus.out_valid, bus.busy}), 64'({1'b0, 1'b1}));
        tick();
        check("bp_next_word", 64'({bus.out_valid, bus.out_idx, bus.out_data}),
              64'({1'b1, 3'd4, 16'h1004}));
        collect(40, -1, saw_done, done_c);
        check("bp_done", 64'(saw_done), 64'(1));
        tick();

        // Start pulsed mid-dump is ignored
        load_seq();
        start_dump();
        collect(60, 2, saw_done, done_c);
        check("late_done_seen", 64'(saw_done), 64'(1));
        check("late_done_cycle", 64'(done_c), 64'(NCYC));
        check("late_word_count", 64'(got_n), 64'(NWORDS));
        for (int i = 0; i < NUM_REGS; i++)
            check($sformatf("late_word_%0d", i),
                  64'({got_idx[i], got_data[i]}), 64'({SEL_W'(i), 16'(16'h1000 + i)}));
        check("late_last_flag", 64'(got_last[NUM_REGS-1]),
`ifdef REGFILE_DUMP_CHECKSUM_EN
              64'(0));
`else
              64'(1));
`endif
        tick();
        check("late_no_queue", 64'({bus.busy, bus.out_valid, bus.done}), 64'(0));

        // Start held through done: back-to-back dumps
        bus.start = 1'b1;
        tick();
        collect(60, -1, saw_done, done_c);
        check("held_first_done", 64'(saw_done), 64'(1));
        tick();
        check("held_restart_fetch", 64'({bus.busy, bus.out_valid, bus.done}),
              64'({1'b1, 1'b0, 1'b0}));
        bus.start = 1'b0;
        tick();
        check("held_restart_word0", 64'({bus.out_valid, bus.out_idx, bus.out_data}),
              64'({1'b1, 3'd0, 16'h1000}));
        collect(60, -1, saw_done, done_c);
        check("held_second_done", 64'(saw_done), 64'(1));
        tick();

        // Reset while idx 5 is presented
        start_dump();
        wait_idx(5, 20, "rst_idx5");
        reset = 1'b0;
        tick();
        check("rst_mid_clear", 64'({bus.out_valid, bus.busy, bus.done, bus.out_last,
                                    bus.out_idx, bus.out_data}), 64'(0));
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_mid_quiet_%0d", i),
                  64'({bus.out_valid, bus.busy, bus.done}), 64'(0));
        end
        start_dump();
        check("rst_restart_fetch", 64'({bus.busy, bus.out_valid}), 64'({1'b1, 1'b0}));
        tick();
        check("rst_restart_word0", 64'({bus.out_valid, bus.out_idx, bus.out_data}),
              64'({1'b1, 3'd0, 16'h1000}));
        collect(60, -1, saw_done, done_c);
        check("rst_restart_done", 64'(saw_done), 64'(1));
        tick();

`ifdef REGFILE_DUMP_CHECKSUM_EN
        // Checksum wraps mod 2^16
        for (int i = 0; i < NUM_REGS; i++) rf[i] = 16'hFFFF;
        start_dump();
        collect(60, -1, saw_done, done_c);
        check("sum_done_cycle", 64'(done_c), 64'(18));
        check("sum_word_count", 64'(got_n), 64'(9));
        check("sum_word", 64'({got_idx[8], got_data[8], got_last[8]}),
              64'({3'd0, 16'hFFF8, 1'b1}));
        check("sum_idx7_not_last", 64'({got_idx[7], got_last[7]}), 64'({3'd7, 1'b0}));
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
